call_stack: RTL
===============

# call_stack

Hardware return-address stack for the multicycle core, directly downstream of the ID-stage control unit. It consumes the control unit's `push`/`pop` decode and its one-cycle `aux_push_pop` strobe. On CALL it saves the return address supplied by the fetch path. On RET it presents the saved address on `ret_addr` for the PC mux (`pcSrc` = 000). Overflow and underflow are flagged as sticky errors; they never corrupt stored entries.

## Interface
- `DATA_WIDTH`, default 32: width of a stored return address.
- `DEPTH`, default 8: number of entries; must be a power of two, ≥ 2.
- `ADDR_WIDTH`, default 3: log2(`DEPTH`).
- `clk` input, 1: single clock; all state changes on its rising edge.
- `reset` input, 1: synchronous, active-high; overrides every other input.
- `push` input, 1: CALL decode from the control unit (level, held all instruction).
- `pop` input, 1: RET decode from the control unit (level, held all instruction).
- `aux_push_pop` input, 1: operation strobe from the control unit.
- `data_in` input, `DATA_WIDTH`: return address to save (PC+1 from fetch).
- `ret_addr` output, `DATA_WIDTH`: last popped address, registered, held until the next successful pop.
- `top` output, `DATA_WIDTH`: current top entry; 0 when empty; debug/observation only.
- `count` output, `ADDR_WIDTH`+1: number of valid entries, 0..`DEPTH`.
- `full` output, 1: `count` == `DEPTH`.
- `empty` output, 1: `count` == 0.
- `overflow` output, 1: sticky; set by a push attempted while full.
- `underflow` output, 1: sticky; set by a pop attempted while empty.

## Operation
- **Internal state:** storage array `mem[DEPTH]`, stack pointer `sp` (`ADDR_WIDTH`+1 bits, equals `count`), strobe delay register `stb_q`.
- **Trigger:** `go` = `aux_push_pop` & ~`stb_q`.
  - `stb_q` <= `aux_push_pop` every cycle.
  - A strobe held high for N cycles performs exactly one operation.
- **Push** (`go` & `push` & ~`pop`):
  - If not full: `mem[sp]` <= `data_in`; `sp` <= `sp`+1.
  - If full: no write, `sp` unchanged, `overflow` <= 1.
- **Pop** (`go` & `pop` & ~`push`):
  - If not empty: `ret_addr` <= `mem[sp-1]`; `sp` <= `sp`-1.
  - If empty: `ret_addr` unchanged, `sp` unchanged, `underflow` <= 1.
- **Push and pop both high with `go`:** no-op. No state change, no flag change.
- **Neither `push` nor `pop` high with `go`:** no-op.
- **`top`:** combinational; `mem[sp-1]` when `sp` > 0, else 0.
- **`full`, `empty`:** combinational decodes of `sp`.
- **Sticky flags:** `overflow` and `underflow` clear only on `reset`.
- **Pointer arithmetic:** `sp` never wraps. It saturates at 0 and at `DEPTH` by the full/empty guards above. Index `mem` with `sp[ADDR_WIDTH-1:0]`.

## Timing
- **Reset values** (edge with `reset`=1): `sp`=0, `count`=0, `empty`=1, `full`=0, `ret_addr`=0, `overflow`=0, `underflow`=0, `stb_q`=0, `top`=0.
- **Memory on reset:** contents are not cleared. They are unobservable, because `top` is forced to 0 when empty.
- **Reset mid-operation:** reset on the same edge as `go` wins. The operation is discarded.
- **Latency:** one cycle. An operation triggered at edge k is visible on `count`, `top`, `ret_addr` and the flags after edge k.
- **Control unit phasing:** `aux_push_pop` is high during stage 2, so the pop completes at the stage 2→3 edge. `ret_addr` is stable through stage 4 and the PCWrite edge. No bypass from `data_in` to `ret_addr` is required.
- **Back-to-back operations:** they require the strobe to drop for at least one cycle between them. A continuously high strobe yields one operation only.

## Test plan
- **Reset:** assert `reset` 2 cycles with `push`=1 and strobe pulsing → `count`=0, `empty`=1, `ret_addr`=0, both flags 0.
- **LIFO order:** push 0x10, 0x20, 0x30 (one 1-cycle strobe each) → `count`=3, `top`=0x30. Then three pops → `ret_addr` = 0x30, 0x20, 0x10 in turn; `empty`=1; `top`=0.
- **Overflow:** push 8 values with `DEPTH`=8 → `full`=1. Ninth push of 0xAA → `overflow`=1, `count`=8, `top` still the eighth value. Pop → returns the eighth value, not 0xAA.
- **Underflow:** after a pop that returned 0x10, pop on empty → `underflow`=1, `ret_addr` stays 0x10, `count`=0. A later push of 0x44 succeeds and `underflow` stays 1.
- **Strobe edge-detect:** hold `aux_push_pop`=1 for 4 cycles with `push`=1 and `data_in`=0x55 → `count` increments by exactly 1.
- **Conflicting decode and reset priority:** `push`=`pop`=1 with a strobe at `count`=2 → no change in any output. Assert `reset` on the same edge as a push strobe → `count`=0 afterwards.

Source files
------------

// File: rtl/call_stack.sv
// call_stack: hardware return-address stack for the multicycle core.
// CALL (push) saves the fetch path's return address; RET (pop) loads the
// saved address into ret_addr for the PC mux. An operation fires once per
// rising edge of aux_push_pop. A push while full sets the sticky overflow
// flag, and a pop while empty sets the sticky underflow flag. Neither case
// touches the stored entries.
//
// Ports:
//   clk, reset          single clock; synchronous active-high reset
//   push, pop           CALL / RET decode levels from the control unit
//   aux_push_pop        operation strobe (edge-detected internally)
//   data_in             return address to save
//   ret_addr            last popped address (registered)
//   top                 current top entry, 0 when empty (observation only)
//   count               number of valid entries, 0..DEPTH
//   full, empty         decodes of count
//   overflow, underflow sticky error flags, cleared only by reset
module call_stack #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  aux_push_pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] ret_addr,
  output logic [DATA_WIDTH-1:0] top,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] DepthVal = DEPTH[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   sp_q;
  logic                  stb_q;
  logic [DATA_WIDTH-1:0] ret_addr_q;
  logic                  overflow_q;
  logic                  underflow_q;

  logic                  go;
  logic                  do_push;
  logic                  do_pop;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [ADDR_WIDTH-1:0] top_idx;

  // A strobe held high for several cycles still fires only one operation.
  assign go      = aux_push_pop & ~stb_q;
  assign do_push = go & push & ~pop;
  assign do_pop  = go & pop & ~push;

  assign full    = (sp_q == DepthVal);
  assign empty   = (sp_q == '0);

  // When sp == DEPTH the low bits are zero, so subtracting one wraps to the
  // last slot. That is the correct top index.
  assign wr_idx  = sp_q[ADDR_WIDTH-1:0];
  assign top_idx = sp_q[ADDR_WIDTH-1:0] - 1'b1;

  assign top       = empty ? '0 : mem[top_idx];
  assign count     = sp_q;
  assign ret_addr  = ret_addr_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q        <= '0;
      stb_q       <= 1'b0;
      ret_addr_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      stb_q <= aux_push_pop;
      if (do_push) begin
        if (full) overflow_q <= 1'b1;
        else      sp_q       <= sp_q + 1'b1;
      end else if (do_pop) begin
        if (empty) begin
          underflow_q <= 1'b1;
        end else begin
          ret_addr_q <= mem[top_idx];
          sp_q       <= sp_q - 1'b1;
        end
      end
    end
  end

  // Storage is never cleared. Stale entries stay hidden because top is
  // forced to 0 when the stack is empty.
  always_ff @(posedge clk) begin
    if (!reset && do_push && !full) begin
      mem[wr_idx] <= data_in;
    end
  end

endmodule
